park: RTL and testbench
=======================

// Module: park
//
// PURPOSE
// - Park transform; the FOC stage directly downstream of the Clarke stage.
// - Rotates the stationary-frame current vector (alpha, beta) into the rotor frame:
//   d = alpha*cos(theta) + beta*sin(theta), q = -alpha*sin(theta) + beta*cos(theta).
// - Uses a quarter-wave sin ROM and one shared multiplier, sequenced by an FSM.
// - Uses the same start/done convention and Q format as the Clarke stage.
//
// PARAMETERS
// - D_WIDTH      18  signed data width of alpha/beta/d/q; Q_BITS fraction bits (range +/-4)
// - Q_BITS       15  fraction bits of data and of sin/cos values
// - THETA_WIDTH  12  unsigned electrical angle width; 2**THETA_WIDTH codes = one full turn
//
// PORTS
// - clk    in   1                clock; all state changes on rising edge
// - rstb   in   1                asynchronous active-low reset
// - alpha  in   D_WIDTH signed   stationary-frame alpha (Clarke output)
// - beta   in   D_WIDTH signed   stationary-frame beta (Clarke output)
// - theta  in   THETA_WIDTH      rotor electrical angle, unsigned, wraps modulo a full turn
// - start  in   1                request; sampled only in IDLE
// - d      out  D_WIDTH signed   direct-axis result, registered
// - q      out  D_WIDTH signed   quadrature-axis result, registered
// - done   out  1                one-cycle pulse: d/q updated this cycle
// - busy   out  1                high from the edge that accepts start until the OUT edge
//
// BEHAVIOUR
// - Reset values: d=0, q=0, done=0, busy=0, FSM=IDLE, accumulators and input captures=0.
// - Reset is asynchronous; asserting it mid-operation aborts the transform.
//   d and q do not complete, and no done pulse is produced for the aborted request.
// - FSM states: IDLE -> LUT -> M0 -> M1 -> M2 -> M3 -> OUT -> IDLE.
//   - IDLE: start=1 captures alpha, beta and theta into registers, sets busy, goes to LUT.
//   - LUT: registered ROM read; sin_r and cos_r are valid in M0.
//   - M0: acc_d = alpha*cos.
//   - M1: acc_d += beta*sin.
//   - M2: acc_q = -(alpha*sin).
//   - M3: acc_q += beta*cos.
//   - OUT: round, shift and saturate both results; load d/q; done=1 for this cycle only; busy=0.
// - Latency: start sampled at edge 0; d/q/done update at edge 6; next start accepted at edge 7.
// - start in any non-IDLE state is ignored, with no queueing; inputs may change freely while busy.
// - d/q hold their last value between transforms. done is 0 in every state except OUT.
// - sin/cos values: signed Q_BITS+2 bits, range [-2**Q_BITS, +2**Q_BITS]; 1.0 is exact.
// - ROM contents: N=2**(THETA_WIDTH-2); N+1 entries L[k]=round(sin(k*pi/(2N))*2**Q_BITS), k=0..N.
// - Quadrant mapping: qd=theta[TW-1:TW-2], i=theta[TW-3:0]:
//   - qd0: sin=L[i],   cos=L[N-i]
//   - qd1: sin=L[N-i], cos=-L[i]
//   - qd2: sin=-L[i],  cos=-L[N-i]
//   - qd3: sin=-L[N-i], cos=L[i]
// - Arithmetic widths:
//   - products are D_WIDTH+Q_BITS+2 bits; accumulators are one bit wider.
//   - result = (acc + 2**(Q_BITS-1)) >>> Q_BITS, arithmetic shift.
//   - The result saturates to [-(2**(D_WIDTH-1)), 2**(D_WIDTH-1)-1]. It never wraps.
// - One multiplier instance is shared across M0..M3; operand muxes are selected by state.
//
// STRUCTURE
// - Shared package foc_pkg holds:
//   - default widths D_WIDTH/Q_BITS/THETA_WIDTH;
//   - park_state_t enum (IDLE, LUT, M0, M1, M2, M3, OUT);
//   - saturate/round helper function, also reusable by inverse Park.
// - Sub-module sincos_lut holds the quarter-wave ROM and quadrant folding.
//   - Inputs: clk, theta. Outputs: sin_r, cos_r, registered with 1-cycle latency.
//   - It is reused by inverse Park.
// - Top level contains the FSM, input capture registers, shared multiplier, accumulators and output stage.
//
// TESTING
// - theta=0, alpha=16384, beta=8192, start 1 cycle -> done at edge 6; d=16384, q=8192.
// - theta=1024 (90 deg), same inputs -> d=8192, q=-16384.
// - theta=2048 (180 deg) -> d=-16384, q=-8192.
// - theta=512 (45 deg), alpha=beta=32767 -> d=46340 +/-1, q=0 +/-1.
// - theta=512, alpha=beta=131071 -> d saturates to 131071, q=0 +/-1.
// - theta=4095: check sin/cos continuity across the wrap to theta=0.
// - Repeat start on edges 1-5 -> ignored, exactly one done pulse.
// - rstb low at edge 3 -> d=q=done=busy=0 immediately; no done afterwards.
// - Scoreboard: random alpha/beta/theta vs a real-valued model; tolerance +/-2 LSB; done is always a 1-cycle pulse.

Source files
------------

// File: rtl/foc_pkg.sv
// Shared FOC definitions: default widths, Park FSM states and the
// round/saturate helper shared by Park and inverse Park.
package foc_pkg;

  localparam int D_WIDTH     = 18;
  localparam int Q_BITS      = 15;
  localparam int THETA_WIDTH = 12;

  localparam int SC_WIDTH   = Q_BITS + 2;
  localparam int PROD_WIDTH = D_WIDTH + Q_BITS + 2;
  localparam int ACC_WIDTH  = PROD_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LUT,
    M0,
    M1,
    M2,
    M3,
    OUT
  } park_state_t;

  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(2 ** (Q_BITS - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'(2 ** (D_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = -SAT_MAX - ACC_WIDTH'(1);

  // Round half-up, drop Q_BITS fraction bits, clamp to the data range.
  function automatic logic signed [D_WIDTH-1:0] round_sat(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic signed [ACC_WIDTH-1:0] r;
    r = (acc + RND_HALF) >>> Q_BITS;
    if (r > SAT_MAX) begin
      return SAT_MAX[D_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[D_WIDTH-1:0];
    end
    return r[D_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sincos_lut.sv
// Quarter-wave sine ROM with quadrant folding; sin_r/cos_r are registered,
// one cycle after theta.
module sincos_lut
  import foc_pkg::*;
(
  input  logic                       clk,
  input  logic [THETA_WIDTH-1:0]     theta,
  output logic signed [SC_WIDTH-1:0] sin_r,
  output logic signed [SC_WIDTH-1:0] cos_r
);

  localparam int N       = 2 ** (THETA_WIDTH - 2);
  localparam int FX_BITS = 30;
  localparam longint PI_FX   = 64'sd3373259426;
  localparam longint ONE_FX  = 64'sd1 <<< FX_BITS;
  localparam longint HALF_FX = 64'sd1 <<< (FX_BITS - Q_BITS - 1);

  // Elaboration-time Taylor series in 2^-30 fixed point, rounded to Q_BITS.
  function automatic logic signed [SC_WIDTH-1:0] rom_entry(input int k);
    longint x;
    longint term;
    longint sum;
    x    = (PI_FX * longint'(k)) / longint'(2 * N);
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((((term * x) / ONE_FX) * x) / ONE_FX) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return SC_WIDTH'((sum + HALF_FX) >>> (FX_BITS - Q_BITS));
  endfunction

  logic signed [SC_WIDTH-1:0] rom [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  logic [1:0]               quad;
  logic [THETA_WIDTH-3:0]   idx_a;
  logic [THETA_WIDTH-2:0]   idx_b;
  logic signed [SC_WIDTH-1:0] val_a;
  logic signed [SC_WIDTH-1:0] val_b;

  assign quad  = theta[THETA_WIDTH-1:THETA_WIDTH-2];
  assign idx_a = theta[THETA_WIDTH-3:0];
  assign idx_b = (THETA_WIDTH - 1)'(N) - {1'b0, idx_a};
  assign val_a = rom[idx_a];
  assign val_b = rom[idx_b];

  always_ff @(posedge clk) begin
    case (quad)
      2'd0: begin sin_r <= val_a;  cos_r <= val_b;  end
      2'd1: begin sin_r <= val_b;  cos_r <= -val_a; end
      2'd2: begin sin_r <= -val_a; cos_r <= -val_b; end
      default: begin sin_r <= -val_b; cos_r <= val_a; end
    endcase
  end

endmodule

// File: rtl/park.sv
// Park transform: rotates (alpha, beta) into the rotor frame using one shared
// multiplier stepped through four products by a small FSM.
module park
  import foc_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstb,
  input  logic signed [D_WIDTH-1:0]     alpha,
  input  logic signed [D_WIDTH-1:0]     beta,
  input  logic [THETA_WIDTH-1:0]        theta,
  input  logic                          start,
  output logic signed [D_WIDTH-1:0]     d,
  output logic signed [D_WIDTH-1:0]     q,
  output logic                          done,
  output logic                          busy,
  output park_state_t                   dbg_state
);

  // Handshake: start is sampled only in IDLE; done pulses for exactly one
  // cycle when d/q change; busy covers accept edge up to the OUT edge.

  park_state_t state_q, state_d;
  logic signed [D_WIDTH-1:0]   alpha_q, alpha_d;
  logic signed [D_WIDTH-1:0]   beta_q, beta_d;
  logic [THETA_WIDTH-1:0]      theta_q, theta_d;
  logic signed [ACC_WIDTH-1:0] accd_q, accd_d;
  logic signed [ACC_WIDTH-1:0] accq_q, accq_d;
  logic signed [D_WIDTH-1:0]   d_q, d_d;
  logic signed [D_WIDTH-1:0]   q_q, q_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;

  logic signed [SC_WIDTH-1:0]   sin_r;
  logic signed [SC_WIDTH-1:0]   cos_r;
  logic signed [D_WIDTH-1:0]    mul_a;
  logic signed [SC_WIDTH-1:0]   mul_b;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

  sincos_lut u_lut (
    .clk   (clk),
    .theta (theta_q),
    .sin_r (sin_r),
    .cos_r (cos_r)
  );

  always_comb begin
    mul_a = alpha_q;
    mul_b = cos_r;
    case (state_q)
      M1:      begin mul_a = beta_q;  mul_b = sin_r; end
      M2:      begin mul_a = alpha_q; mul_b = sin_r; end
      M3:      begin mul_a = beta_q;  mul_b = cos_r; end
      default: ;
    endcase
    prod     = PROD_WIDTH'(mul_a) * PROD_WIDTH'(mul_b);
    prod_ext = ACC_WIDTH'(prod);
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    theta_d = theta_q;
    accd_d  = accd_q;
    accq_d  = accq_q;
    d_d     = d_q;
    q_d     = q_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          alpha_d = alpha;
          beta_d  = beta;
          theta_d = theta;
          busy_d  = 1'b1;
          state_d = LUT;
        end
      end
      LUT: state_d = M0;
      M0: begin
        accd_d  = prod_ext;
        state_d = M1;
      end
      M1: begin
        accd_d  = accd_q + prod_ext;
        state_d = M2;
      end
      M2: begin
        accq_d  = -prod_ext;
        state_d = M3;
      end
      M3: begin
        accq_d  = accq_q + prod_ext;
        state_d = OUT;
      end
      OUT: begin
        d_d     = round_sat(accd_q);
        q_d     = round_sat(accq_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      alpha_q <= '0;
      beta_q  <= '0;
      theta_q <= '0;
      accd_q  <= '0;
      accq_q  <= '0;
      d_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      theta_q <= theta_d;
      accd_q  <= accd_d;
      accq_q  <= accq_d;
      d_q     <= d_d;
      q_q     <= q_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign d         = d_q;
  assign q         = q_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_park.sv
// Self-checking bench for park: directed cases, start-while-busy, reset abort
// and random vectors against a real-valued rotation model.
module tb_park;
  import foc_pkg::*;

  logic                       clk;
  logic                       rstb;
  logic signed [D_WIDTH-1:0]  alpha;
  logic signed [D_WIDTH-1:0]  beta;
  logic [THETA_WIDTH-1:0]     theta;
  logic                       start;
  logic signed [D_WIDTH-1:0]  d;
  logic signed [D_WIDTH-1:0]  q;
  logic                       done;
  logic                       busy;
  park_state_t                dbg_state;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  logic [2*D_WIDTH-1:0] exp_q[$];
  int                   tol_q[$];

  park u_dut (
    .clk       (clk),
    .rstb      (rstb),
    .alpha     (alpha),
    .beta      (beta),
    .theta     (theta),
    .start     (start),
    .d         (d),
    .q         (q),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int expv, input int tol);
    checks++;
    assert ((obs - expv) <= tol && (expv - obs) <= tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  function automatic int sat_d(input real x);
    real r;
    r = $floor(x + 0.5);
    if (r > 131071.0) return 131071;
    if (r < -131072.0) return -131072;
    return $rtoi(r);
  endfunction

  task automatic model(input int a, input int b, input int th, output int ed, output int eq);
    real ang;
    real s;
    real c;
    ang = 6.283185307179586 * th / 4096.0;
    s   = $sin(ang);
    c   = $cos(ang);
    ed  = sat_d(a * c + b * s);
    eq  = sat_d(-a * s + b * c);
  endtask

  // Scoreboard: every done pops one expectation and checks pulse width.
  always @(negedge clk) begin
    logic [2*D_WIDTH-1:0] e;
    int t;
    if (!rstb) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        check_eq("done_width", int'(done_prev), 0);
        check_eq("done_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tol_q.pop_front();
          check_tol("d", int'(d), int'($signed(e[2*D_WIDTH-1:D_WIDTH])), t);
          check_tol("q", int'(q), int'($signed(e[D_WIDTH-1:0])), t);
        end
      end
      done_prev = done;
    end
  end

  task automatic xform(input int a, input int b, input int th,
                       input int ed, input int eq, input int tol);
    int n;
    @(negedge clk);
    alpha = D_WIDTH'(a);
    beta  = D_WIDTH'(b);
    theta = THETA_WIDTH'(th);
    start = 1'b1;
    exp_q.push_back({D_WIDTH'(ed), D_WIDTH'(eq)});
    tol_q.push_back(tol);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", int'(busy), 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, 7);
    @(negedge clk);
    check_eq("busy_after_done", int'(busy), 0);
  endtask

  task automatic xform_model(input int a, input int b, input int th, input int tol);
    int ed;
    int eq;
    model(a, b, th, ed, eq);
    xform(a, b, th, ed, eq, tol);
  endtask

  initial begin
    int cnt0;
    int a;
    int b;
    int th;
    rstb  = 1'b0;
    alpha = '0;
    beta  = '0;
    theta = '0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_d", int'(d), 0);
    check_eq("rst_q", int'(q), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_state", int'(dbg_state), int'(IDLE));
    rstb = 1'b1;
    @(negedge clk);

    // Axis-aligned angles: sin/cos are exactly 0 or +/-1.
    xform(16384, 8192, 0,    16384,  8192,   0);
    xform(16384, 8192, 1024, 8192,   -16384, 0);
    xform(16384, 8192, 2048, -16384, -8192,  0);
    xform(16384, 8192, 3072, -8192,  16384,  0);
    // 45 degrees and saturation in both directions.
    xform(32767,  32767,  512,  46340,   0, 1);
    xform(131071, 131071, 512,  131071,  0, 1);
    xform(131071, 131071, 2560, -131072, 0, 1);
    // Wrap continuity around theta = 0.
    xform_model(30000, -20000, 4095, 2);
    xform_model(30000, -20000, 0,    2);
    xform_model(30000, -20000, 1,    2);

    // start held through the busy window: exactly one result.
    cnt0 = done_cnt;
    @(negedge clk);
    alpha = 18'sd10000;
    beta  = -18'sd5000;
    theta = 12'd0;
    start = 1'b1;
    exp_q.push_back({18'sd10000, -18'sd5000});
    tol_q.push_back(0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      alpha = D_WIDTH'($urandom_range(60000));
      beta  = D_WIDTH'($urandom_range(60000));
      theta = THETA_WIDTH'($urandom_range(4095));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("repeat_start_dones", done_cnt - cnt0, 1);

    // Asynchronous reset three edges into a transform aborts it.
    cnt0 = done_cnt;
    @(negedge clk);
    alpha = 18'sd20000;
    beta  = 18'sd20000;
    theta = 12'd100;
    start = 1'b1;
    repeat (2) @(posedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    check_eq("abort_d", int'(d), 0);
    check_eq("abort_q", int'(q), 0);
    check_eq("abort_done", int'(done), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rstb = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", done_cnt - cnt0, 0);

    // Random vectors, kept small enough that ROM quantisation stays in tolerance.
    for (int k = 0; k < 16; k++) begin
      a  = int'($urandom_range(80000)) - 40000;
      b  = int'($urandom_range(80000)) - 40000;
      th = int'($urandom_range(4095));
      xform_model(a, b, th, 2);
    end

    repeat (4) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
